fp_pack: RTL and testbench

Pipelined floating-point packer: accepts an unpacked result (sign, biased extended exponent, normalized mantissa with guard/round/sticky bits, plus special-value flags), rounds to nearest-even, and assembles the IEEE-754-style word. It is the output-side counterpart of the special-value classifier. The classifier decodes nan/inf/zero from a packed word; fp_pack encodes them back and handles overflow and underflow. It sits at the tail of every Versat FP arithmetic unit, between the datapath core and the result stream.

---
 rtl/fp_pack.sv | 162 ++++++++++++++++
 tb/tb_fp_pack.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_pack.sv
// Two-stage elastic floating-point packer: rounds to nearest-even, then encodes specials,
// overflow and flush-to-zero underflow. Define FP_PACK_SATURATE_EN to saturate on overflow.
module fp_pack #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      sign_i,
  input  logic [EXP_W+1:0]          exp_i,
  input  logic [DATA_W-EXP_W+2:0]   man_i,
  input  logic                      nan_i,
  input  logic                      inf_i,
  input  logic                      zero_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      overflow_o,
  output logic                      underflow_o,
  output logic                      inexact_o
);

  localparam int unsigned MAN_W = DATA_W - EXP_W;
  localparam logic signed [EXP_W+2:0] EMax = (EXP_W+3)'((2 ** EXP_W) - 1);

  // Stage 1 state
  logic                 v1_q, v1_d;
  logic                 sign1_q, sign1_d;
  logic [EXP_W+1:0]     exp1_q, exp1_d;
  logic                 carry1_q, carry1_d;
  logic [MAN_W-2:0]     frac1_q, frac1_d;
  logic                 inx1_q, inx1_d;
  logic                 nan1_q, nan1_d;
  logic                 inf1_q, inf1_d;
  logic                 zero1_q, zero1_d;

  // Stage 2 state
  logic                 v2_q, v2_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 inx_q, inx_d;

  logic                 en1, en2;
  logic                 inc;
  logic                 fcarry;
  logic [MAN_W-2:0]     fsum;
  logic signed [EXP_W+2:0] e;
  logic [MAN_W-2:0]     frac;

  assign en2     = ~v2_q | ready_i;
  assign en1     = ~v1_q | en2;
  assign ready_o = en1;

  // Round: the fraction carry only reaches past the hidden bit when the hidden bit is set.
  always_comb begin
    inc            = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
    {fcarry, fsum} = {1'b0, man_i[MAN_W+1:3]} + MAN_W'(inc);

    v1_d     = en1 ? valid_i : v1_q;
    sign1_d  = sign1_q;
    exp1_d   = exp1_q;
    carry1_d = carry1_q;
    frac1_d  = frac1_q;
    inx1_d   = inx1_q;
    nan1_d   = nan1_q;
    inf1_d   = inf1_q;
    zero1_d  = zero1_q;
    if (en1 && valid_i) begin
      sign1_d  = sign_i;
      exp1_d   = exp_i;
      carry1_d = fcarry & man_i[MAN_W+2];
      frac1_d  = fsum;
      inx1_d   = |man_i[2:0];
      nan1_d   = nan_i;
      inf1_d   = inf_i;
      zero1_d  = zero_i;
    end
  end

  // Pack
  always_comb begin
    e    = $signed({exp1_q[EXP_W+1], exp1_q}) + $signed({{(EXP_W+2){1'b0}}, carry1_q});
    frac = carry1_q ? '0 : frac1_q;

    v2_d   = en2 ? v1_q : v2_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    inx_d  = inx_q;
    if (en2 && v1_q) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
      if (nan1_q) begin
        data_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-2){1'b0}}};
      end else if (inf1_q) begin
        data_d = {sign1_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
      end else if (zero1_q) begin
        data_d = {sign1_q, {(DATA_W-1){1'b0}}};
      end else if (e >= EMax) begin
        ovf_d = 1'b1;
        inx_d = 1'b1;
`ifdef FP_PACK_SATURATE_EN
        data_d = {sign1_q, {(EXP_W-1){1'b1}}, 1'b0, {(MAN_W-1){1'b1}}};
`else
        data_d = {sign1_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
`endif
      end else if (e[EXP_W+2] || (e == '0)) begin
        unf_d  = 1'b1;
        inx_d  = 1'b1;
        data_d = {sign1_q, {(DATA_W-1){1'b0}}};
      end else begin
        inx_d  = inx1_q;
        data_d = {sign1_q, e[EXP_W-1:0], frac};
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      exp1_q   <= '0;
      carry1_q <= 1'b0;
      frac1_q  <= '0;
      inx1_q   <= 1'b0;
      nan1_q   <= 1'b0;
      inf1_q   <= 1'b0;
      zero1_q  <= 1'b0;
      v2_q     <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      sign1_q  <= sign1_d;
      exp1_q   <= exp1_d;
      carry1_q <= carry1_d;
      frac1_q  <= frac1_d;
      inx1_q   <= inx1_d;
      nan1_q   <= nan1_d;
      inf1_q   <= inf1_d;
      zero1_q  <= zero1_d;
      v2_q     <= v2_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign valid_o     = v2_q;
  assign data_o      = data_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_pack.sv
// Directed-vector bench for fp_pack: table of rounding/special/overflow/underflow cases,
// then backpressure buffering and mid-stream asynchronous reset sequences.
module tb_fp_pack;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] man;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

`ifdef FP_PACK_SATURATE_EN
  localparam logic [31:0] OvfPos = 32'h7F7FFFFF;
  localparam logic [31:0] OvfNeg = 32'hFF7FFFFF;
`else
  localparam logic [31:0] OvfPos = 32'h7F800000;
  localparam logic [31:0] OvfNeg = 32'hFF800000;
`endif

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        sign_i = 1'b0;
  logic [9:0]  exp_i = '0;
  logic [26:0] man_i = '0;
  logic        nan_i = 1'b0;
  logic        inf_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  fp_pack #(.DATA_W(32), .EXP_W(8)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sign_i     (sign_i),
    .exp_i      (exp_i),
    .man_i      (man_i),
    .nan_i      (nan_i),
    .inf_i      (inf_i),
    .zero_i     (zero_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o),
    .inexact_o  (inexact_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  bit          mon_en = 1'b0;
  logic [31:0] mon_q[$];

  // A beat seen valid and accepted at the negedge transfers on the following posedge.
  always @(negedge clk_i) begin
    if (mon_en && valid_o && ready_i) mon_q.push_back(data_o);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [26:0] m,
                              input logic n, input logic i, input logic z,
                              input logic [31:0] d, input logic o, input logic u,
                              input logic x);
    vec_t v;
    v.sign = s; v.exp = e; v.man = m; v.nan = n; v.inf = i; v.zero = z;
    v.data = d; v.ovf = o; v.unf = u; v.inx = x;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic vld);
    sign_i  = v.sign;
    exp_i   = v.exp;
    man_i   = v.man;
    nan_i   = v.nan;
    inf_i   = v.inf;
    zero_i  = v.zero;
    valid_i = vld;
  endtask

  vec_t vecs[$];
  int   bp_idx[4];

  initial begin
    int lat;
    bit got;
    bit acc;
    int sent;
    int stale;

    vecs.push_back(mk(0, 10'd127, 27'h4000000, 0, 0, 0, 32'h3F800000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd127, 27'h7FFFFFC, 0, 0, 0, 32'h40000000, 0, 0, 1));
    vecs.push_back(mk(0, 10'd127, 27'h4000004, 0, 0, 0, 32'h3F800000, 0, 0, 1));
    vecs.push_back(mk(0, 10'd255, 27'h4000000, 0, 0, 0, OvfPos,       1, 0, 1));
    vecs.push_back(mk(1, 10'd255, 27'h4000000, 0, 0, 0, OvfNeg,       1, 0, 1));
    vecs.push_back(mk(1, 10'd127, 27'h4000000, 1, 1, 0, 32'h7FC00000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd127, 27'h4000000, 0, 0, 1, 32'h80000000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd127, 27'h4000000, 0, 1, 0, 32'h7F800000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd0,   27'h4000000, 0, 0, 0, 32'h80000000, 0, 1, 1));
    vecs.push_back(mk(1, 10'h3FB, 27'h4000000, 0, 0, 0, 32'h80000000, 0, 1, 1));
    vecs.push_back(mk(0, 10'd254, 27'h7FFFFFC, 0, 0, 0, OvfPos,       1, 0, 1));
    vecs.push_back(mk(0, 10'd1,   27'h4000000, 0, 0, 0, 32'h00800000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd128, 27'h6000000, 0, 0, 0, 32'h40400000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd127, 27'h400000C, 0, 0, 0, 32'h3F800002, 0, 0, 1));
    vecs.push_back(mk(0, 10'd127, 27'h4000001, 0, 0, 0, 32'h3F800000, 0, 0, 1));
    vecs.push_back(mk(1, 10'd255, 27'h7FFFFFF, 1, 0, 1, 32'h7FC00000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd0,   27'h0000000, 0, 1, 1, 32'hFF800000, 0, 0, 0));
    bp_idx = '{12, 1, 13, 11};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset valid_o", 64'(valid_o), 64'd0);
    chk("reset data_o", 64'(data_o), 64'd0);
    chk("reset flags", 64'({overflow_o, underflow_o, inexact_o}), 64'd0);
    chk("reset ready_o", 64'(ready_o), 64'd1);
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk_i);
        if (valid_o) begin
          got = 1'b1;
          break;
        end
        @(posedge clk_i);
        #1;
        lat++;
      end
      chk($sformatf("vec%0d valid_o seen", i), 64'(got), 64'd1);
      if (got) begin
        chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
        chk($sformatf("vec%0d data_o", i), 64'(data_o), 64'(vecs[i].data));
        chk($sformatf("vec%0d flags", i), 64'({overflow_o, underflow_o, inexact_o}),
            64'({vecs[i].ovf, vecs[i].unf, vecs[i].inx}));
        @(posedge clk_i);
        #1;
      end
    end

    // Backpressure: ready_i low for 5 cycles while 4 beats are offered
    repeat (3) @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    mon_en  = 1'b1;
    sent    = 0;
    drive(vecs[bp_idx[0]], 1'b1);
    for (int cyc = 0; cyc < 40 && sent < 4; cyc++) begin
      @(negedge clk_i);
      acc = valid_i && ready_o;
      if (cyc >= 2 && cyc <= 4) begin
        chk($sformatf("stall c%0d ready_o", cyc), 64'(ready_o), 64'd0);
        chk($sformatf("stall c%0d valid_o", cyc), 64'(valid_o), 64'd1);
        chk($sformatf("stall c%0d data_o", cyc), 64'(data_o), 64'(vecs[bp_idx[0]].data));
      end
      @(posedge clk_i);
      #1;
      if (acc) sent++;
      if (cyc == 4) begin
        chk("beats captured during stall", 64'(sent), 64'd2);
        ready_i = 1'b1;
      end
      if (sent < 4) drive(vecs[bp_idx[sent]], 1'b1);
      else valid_i = 1'b0;
    end
    chk("all beats accepted", 64'(sent), 64'd4);
    for (int k = 0; k < 20 && mon_q.size() < 4; k++) @(posedge clk_i);
    #1;
    chk("output beat count", 64'(mon_q.size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < mon_q.size())
        chk($sformatf("bp beat%0d data", j), 64'(mon_q[j]), 64'(vecs[bp_idx[j]].data));
    end
    mon_en = 1'b0;

    // Mid-stream asynchronous reset with two beats in flight
    repeat (3) @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    drive(vecs[1], 1'b1);
    @(posedge clk_i);
    #1;
    drive(vecs[12], 1'b1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("pre-reset valid_o", 64'(valid_o), 64'd1);
    #2 arst_n_i = 1'b0;
    #1;
    chk("async reset valid_o", 64'(valid_o), 64'd0);
    chk("async reset data_o", 64'(data_o), 64'd0);
    chk("async reset ready_o", 64'(ready_o), 64'd1);
    arst_n_i = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (valid_o) stale++;
    end
    chk("stale beats after reset", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
